// File: rtl/ISA.sv
`default_nettype none
// ============================================================================
// Module   : ISA (package)
// Purpose  : RV32 instruction-set constants shared across the pipeline.
// Revision : 1.0  initial release
// ============================================================================
package ISA;

  // addi x0, x0, 0 -- decoded as an I-type with no architectural effect
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/PipelineReg.sv
`default_nettype none
// ============================================================================
// Module   : PipelineReg (package)
// Purpose  : Inter-stage pipeline register payloads.
// Revision : 1.0  initial release
// ============================================================================
package PipelineReg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } ID_STATE;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Local constants and helpers for the instruction-fetch stage.
// Revision : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] c_pc_step = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : DEPTH-entry synchronous FIFO with flush; head is read combinationally.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full      = (r_count == c_cnt_w'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];

  // Flush wins over both push and pop in the same cycle.
  assign w_do_pop  = i_pop && !i_flush && !o_empty;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && o_full && !i_pop));

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32 IF stage: PC, imem request/response handshake, in-order
//            instruction queue to decode, redirect flush with stale-drop.
//            Optional perf counters when FETCH_PERF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [31:0]          imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output PipelineReg::ID_STATE id_state,
  output logic                 id_valid,
  input  logic                 id_stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushed,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_sum_w = c_cnt_w + 1;

  logic [31:0]          r_pc;
  logic [31:0]          r_last_pc;
  logic [c_cnt_w-1:0]   r_outstanding;
  logic [c_cnt_w-1:0]   r_drop_cnt;

  PipelineReg::ID_STATE w_iq_head;
  logic [c_cnt_w-1:0]   w_iq_count;
  logic                 w_iq_full;
  logic                 w_iq_empty;
  logic [31:0]          w_tag_head;
  logic [c_cnt_w-1:0]   w_tag_count;
  logic                 w_tag_full;
  logic                 w_tag_empty;

  logic                 w_rsp_fire;
  logic                 w_rsp_drop;
  logic                 w_rsp_push;
  logic                 w_pop;
  logic                 w_req_fire;
  logic [c_sum_w-1:0]   w_slots_used;

  assign w_rsp_fire = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop = w_rsp_fire && (redirect_valid || (r_drop_cnt != '0));
  assign w_rsp_push = w_rsp_fire && !w_rsp_drop;
  assign w_pop      = !w_iq_empty && !id_stall && !redirect_valid;

  // A head leaving this cycle frees its slot for a new request, which is what
  // lets a 1-cycle memory sustain one instruction per cycle with DEPTH=2.
  assign w_slots_used   = c_sum_w'(w_iq_count) + c_sum_w'(r_outstanding) - c_sum_w'(w_pop);
  assign imem_req_valid = rst_n && !redirect_valid && (w_slots_used < c_sum_w'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign id_valid = !w_iq_empty;
  always_comb begin
    id_state = w_iq_head;
    if (w_iq_empty) begin
      id_state.pc          = r_last_pc;
      id_state.instruction = ISA::RV_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_last_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        // Everything still in flight is now stale, including earlier drops.
        r_pc          <= word_align(redirect_pc);
        r_outstanding <= r_outstanding - c_cnt_w'(w_rsp_fire);
        r_drop_cnt    <= r_outstanding - c_cnt_w'(w_rsp_fire);
      end else begin
        if (w_req_fire) r_pc <= r_pc + c_pc_step;
        r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_fire);
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
      end
      if (!w_iq_empty) r_last_pc <= w_iq_head.pc;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH),
    .WIDTH($bits(PipelineReg::ID_STATE))
  ) u_instr_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_rsp_push),
    .i_push_data ({w_tag_head, imem_rsp_data}),
    .i_pop       (w_pop),
    .o_head_data (w_iq_head),
    .o_count     (w_iq_count),
    .o_full      (w_iq_full),
    .o_empty     (w_iq_empty)
  );

  fetch_queue #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_tag_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_req_fire),
    .i_push_data (r_pc),
    .i_pop       (w_rsp_push),
    .o_head_data (w_tag_head),
    .o_count     (w_tag_count),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_flushed      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_fetched      <= sat_add(perf_fetched, 32'(w_rsp_push));
      perf_flushed      <= sat_add(perf_flushed,
                             (redirect_valid ? 32'(w_iq_count) : 32'd0) + 32'(w_rsp_drop));
      perf_stall_cycles <= sat_add(perf_stall_cycles, 32'(id_valid && id_stall));
    end
  end
`endif

  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (r_outstanding == '0)));
  a_tag_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    w_tag_count == (r_outstanding - r_drop_cnt));
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp_push && w_tag_empty));
  a_room_for_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !((w_rsp_push && w_iq_full && !w_pop) || (w_req_fire && w_tag_full)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage with a fixed-latency imem model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_data_key = 32'hA5A5_0000;
  localparam logic [31:0] c_nop      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  PipelineReg::ID_STATE id_state;
  logic        id_valid;
  logic        id_stall = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_stall_cycles;
`endif

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_state       (id_state),
    .id_valid       (id_valid),
    .id_stall       (id_stall)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_flushed      (perf_flushed),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rel = 0;
  int          lat = 1;
  int          limit = 0;
  int          accepted = 0;
  int          first_valid = -1;
  bit          hold_ready = 1'b0;
  logic [31:0] model_pc = '0;
  int          acc_cyc [16];
  mem_t        mem_q [$];
  logic [31:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ c_data_key;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc - rel);
    end
  endtask

  // Memory: fixed latency, accepts while under the scenario's request budget.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = (accepted < limit) && !hold_ready;
  end

  // Request side: addresses must follow a PC model advanced by accepts and redirects.
  always @(negedge clk) begin : p_req_mon
    mem_t m;
    if (rst_n) begin
      if (redirect_valid) begin
        check("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        model_pc = redirect_pc & ~32'h3;
      end else if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, model_pc);
        if (accepted < 16) acc_cyc[accepted] = cyc - rel;
        m.due  = cyc + lat;
        m.addr = imem_req_addr;
        mem_q.push_back(m);
        accepted++;
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Decode side: every instruction consumed is popped from the scoreboard.
  always @(negedge clk) begin : p_id_mon
    logic [31:0] e;
    if (rst_n && id_valid && !id_stall && !redirect_valid) begin
      if (first_valid < 0) first_valid = cyc - rel;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_instr: got pc %h, expected none", id_state.pc);
      end else begin
        e = exp_q.pop_front();
        check("id_pc", id_state.pc, e);
        check("id_instr", id_state.instruction, mem_word(e));
      end
    end
  end

  task automatic apply_reset(input int l, input int lim);
    rst_n          = 1'b0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    hold_ready     = 1'b0;
    lat            = l;
    limit          = lim;
    accepted       = 0;
    model_pc       = 32'h0;
    first_valid    = -1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_pc", id_state.pc, 32'h0);
    check("rst_id_instr", id_state.instruction, c_nop);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_flushed", perf_flushed, 32'd0);
    check("rst_perf_stall", perf_stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel   = cyc;
  endtask

  task automatic go_cycle(input int k);
    while (cyc - rel < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d instrs still expected after %0d cycles", name, exp_q.size(), n);
    end
    repeat (8) @(posedge clk);
    #1;
    check({name, "_accepted"}, 32'(accepted), 32'(limit));
  endtask

  initial begin
    // Streaming with a 1-cycle memory.
    apply_reset(1, 6);
    expect_run(32'h0, 6);
    drain("basic");
    check("acc_cycle0", 32'(acc_cyc[0]), 32'd0);
    check("acc_cycle1", 32'(acc_cyc[1]), 32'd1);
    check("acc_cycle2", 32'(acc_cyc[2]), 32'd2);
    check("first_id_valid_cycle", 32'(first_valid), 32'd2);

    // Decoder stall with head at 0x8.
    apply_reset(1, 7);
    expect_run(32'h0, 7);
    go_cycle(4);
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_id_valid", 32'(id_valid), 32'd1);
      check("stall_head_pc", id_state.pc, 32'h8);
      if (i > 0) check("stall_no_req", 32'(imem_req_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    id_stall = 1'b0;
    drain("stall");
`ifdef FETCH_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, 32'd3);
    check("perf_fetched_stall", perf_fetched, 32'd7);
`endif

    // Memory not ready for 4 cycles while PC is 0x8.
    apply_reset(1, 5);
    expect_run(32'h0, 5);
    go_cycle(1);
    @(negedge clk);
    hold_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_req_valid", 32'(imem_req_valid), 32'd1);
      check("hold_addr", imem_req_addr, 32'h8);
      if (i == 3) hold_ready = 1'b0;
    end
    drain("ready_low");

    // Redirect to 0x103 with two requests in flight, 3-cycle memory.
    apply_reset(3, 6);
    expect_run(32'h100, 4);
    go_cycle(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain("redirect");
`ifdef FETCH_PERF_EN
    check("perf_flushed", perf_flushed, 32'd2);
    check("perf_fetched", perf_fetched, 32'd4);
    check("perf_stall_zero", perf_stall_cycles, 32'd0);
`endif

    // Back-to-back redirects, the second lands while a stale response returns.
    apply_reset(3, 6);
    expect_run(32'h80, 4);
    go_cycle(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(posedge clk);
    #1;
    redirect_pc    = 32'h80;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain("b2b_redirect");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
